// File: rtl/mult8_sched_if.sv
// Bus between the 8x8 multiply sequencer, its requester and the shared 4x4
// array multiplier.
//   start     request a new multiply (honoured only while idle)
//   a, b      8-bit operands, captured when a request is accepted
//   ma, mb    operand nibbles presented to the shared 4x4 multiplier
//   mp        8-bit product returned combinationally by that multiplier
//   busy      sequencer is not idle
//   done      one-cycle pulse, p holds the new result
//   p         last completed 16-bit product
// master: requester and multiplier side. slave: the sequencer.
interface mult8_sched_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic [7:0]  mp;
    logic        busy;
    logic        done;
    logic [15:0] p;

    modport master (output start, a, b, mp,
                    input  ma, mb, busy, done, p);

    modport slave  (input  start, a, b, mp,
                    output ma, mb, busy, done, p);
endinterface

// File: rtl/mult8_sched.sv
// Unsigned 8x8 -> 16-bit multiply sequencer built around one shared,
// combinational 4x4 multiplier. The four nibble partial products are taken
// on consecutive cycles and summed with zero-filled shifts.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    mult8_sched_if.slave (start/a/b in, ma/mb out, mp in,
//          busy/done/p out)
// Parameter:
//   EARLY_ZERO  when 1, a request with a zero operand skips the partial
//               products and completes with p = 0 one edge later.
//
// state | meaning
// IDLE  | waiting for start; ma/mb = 0
// LL    | low A nibble x low B nibble, added unshifted
// LH    | low A nibble x high B nibble, added << 4
// HL    | high A nibble x low B nibble, added << 4
// HH    | high x high, added << 8 straight into p; done registered
// DONE  | done high, p valid; ma/mb = 0
module mult8_sched #(
    parameter bit EARLY_ZERO = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mult8_sched_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LL,
        S_LH,
        S_HL,
        S_HH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ar_q, ar_d;
    logic [7:0]  br_q, br_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;
    logic        done_q, done_d;
    logic [3:0]  ma, mb;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ar_q    <= '0;
            br_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    // Nibble selects come only from state and the captured operands, so
    // there is no combinational path from a/b through mp back into ma/mb.
    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        br_d    = br_q;
        acc_d   = acc_q;
        p_d     = p_q;
        done_d  = 1'b0;
        ma      = 4'd0;
        mb      = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ar_d  = bus.a;
                    br_d  = bus.b;
                    acc_d = '0;
                    if (EARLY_ZERO && (bus.a == 8'd0 || bus.b == 8'd0)) begin
                        p_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LL;
                    end
                end
            end
            S_LL: begin
                ma      = ar_q[3:0];
                mb      = br_q[3:0];
                acc_d   = acc_q + {8'd0, bus.mp};
                state_d = S_LH;
            end
            S_LH: begin
                ma      = ar_q[3:0];
                mb      = br_q[7:4];
                acc_d   = acc_q + {4'd0, bus.mp, 4'd0};
                state_d = S_HL;
            end
            S_HL: begin
                ma      = ar_q[7:4];
                mb      = br_q[3:0];
                acc_d   = acc_q + {4'd0, bus.mp, 4'd0};
                state_d = S_HH;
            end
            S_HH: begin
                ma      = ar_q[7:4];
                mb      = br_q[7:4];
                // Final term goes straight to p; 255*255 fits in 16 bits.
                p_d     = acc_q + {bus.mp, 8'd0};
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ma   = ma;
    assign bus.mb   = mb;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule

// File: tb/tb_mult8_sched.sv
module tb_mult8_sched;

    logic       clk;
    logic       rst;
    logic       start_r;
    logic [7:0] a_r;
    logic [7:0] b_r;

    int n_checks = 0;
    int n_fail   = 0;

    mult8_sched_if if0 ();
    mult8_sched_if if1 ();

    // Shared inputs; reference 4x4 multiplier on each bus.
    assign if0.start = start_r;
    assign if0.a     = a_r;
    assign if0.b     = b_r;
    assign if0.mp    = 8'(if0.ma) * 8'(if0.mb);
    assign if1.start = start_r;
    assign if1.a     = a_r;
    assign if1.b     = b_r;
    assign if1.mp    = 8'(if1.ma) * 8'(if1.mb);

    mult8_sched #(.EARLY_ZERO(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
    mult8_sched #(.EARLY_ZERO(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        a_r = a;
        b_r = b;
        start_r = 1'b1;
        step();
        start_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_r = 1'b1;
        a_r = 8'h55;
        b_r = 8'h66;
        step();
        step();
        n_checks++;
        if ({if0.busy, if0.done, if0.p, if0.ma, if0.mb} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: busy=%0b done=%0b p=%h ma=%h mb=%h, want all zero",
                     if0.busy, if0.done, if0.p, if0.ma, if0.mb);
        end
        n_checks++;
        if ({if1.busy, if1.done, if1.p, if1.ma, if1.mb} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: busy=%0b done=%0b p=%h ma=%h mb=%h, want all zero",
                     if1.busy, if1.done, if1.p, if1.ma, if1.mb);
        end
        start_r = 1'b0;
        rst = 1'b0;
        step();
    endtask

    // Fixed vectors followed by random nonzero operands; inputs are scrambled
    // while busy to show the captured operands are what get multiplied.
    task automatic test_products();
        logic [7:0] va[$];
        logic [7:0] vb[$];
        va.push_back(8'h12); vb.push_back(8'h34);
        va.push_back(8'hFF); vb.push_back(8'hFF);
        for (int i = 0; i < 8; i++) begin
            va.push_back(8'($urandom_range(1, 255)));
            vb.push_back(8'($urandom_range(1, 255)));
        end
        foreach (va[i]) begin
            logic [7:0] a;
            logic [7:0] b;
            int         prod;
            a = va[i];
            b = vb[i];
            prod = int'(a) * int'(b);
            start_op(a, b);
            for (int j = 0; j < 4; j++) begin
                int ema;
                int emb;
                ema = (j < 2) ? (a % 16) : (a / 16);
                emb = (j % 2 == 0) ? (b % 16) : (b / 16);
                n_checks++;
                if (if0.ma !== 4'(ema) || if0.mb !== 4'(emb) || if0.busy !== 1'b1 || if0.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nibble_seq op%0d step%0d: ma=%h mb=%h busy=%0b done=%0b, want ma=%h mb=%h busy=1 done=0",
                             i, j, if0.ma, if0.mb, if0.busy, if0.done, ema, emb);
                end
                a_r = 8'($urandom);
                b_r = 8'($urandom);
                start_r = 1'($urandom);
                step();
            end
            n_checks++;
            if (if0.done !== 1'b1 || if0.p !== 16'(prod) || if0.busy !== 1'b1 || if0.ma !== 4'd0 || if0.mb !== 4'd0) begin
                n_fail++;
                $display("FAIL product op%0d %h*%h: done=%0b p=%h busy=%0b ma=%h mb=%h, want done=1 p=%h busy=1 ma=mb=0",
                         i, a, b, if0.done, if0.p, if0.busy, if0.ma, if0.mb, 16'(prod));
            end
            n_checks++;
            if (if1.done !== 1'b1 || if1.p !== 16'(prod)) begin
                n_fail++;
                $display("FAIL product_ez op%0d: done=%0b p=%h, want done=1 p=%h",
                         i, if1.done, if1.p, 16'(prod));
            end
            step();
            start_r = 1'b0;
            n_checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.p !== 16'(prod)) begin
                n_fail++;
                $display("FAIL after_done op%0d: done=%0b busy=%0b p=%h, want done=0 busy=0 p=%h",
                         i, if0.done, if0.busy, if0.p, 16'(prod));
            end
        end
    endtask

    // Start held high: one result per 6 cycles, starts while busy ignored.
    task automatic test_back_to_back();
        int ndone = 0;
        a_r = 8'h0F;
        b_r = 8'h10;
        start_r = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            n_checks++;
            if (if0.done !== (k % 6 == 4) || if0.busy !== (k % 6 != 5)) begin
                n_fail++;
                $display("FAIL held_start cycle%0d: done=%0b busy=%0b, want done=%0b busy=%0b",
                         k, if0.done, if0.busy, (k % 6 == 4), (k % 6 != 5));
            end
            if (k % 6 == 4) begin
                ndone++;
                n_checks++;
                if (if0.p !== 16'h00F0) begin
                    n_fail++;
                    $display("FAIL held_start_p cycle%0d: p=%h, want 00f0", k, if0.p);
                end
            end
        end
        start_r = 1'b0;
        n_checks++;
        if (ndone != 3) begin
            n_fail++;
            $display("FAIL held_start_count: saw %0d results, want 3", ndone);
        end
    endtask

    task automatic test_reset_mid_op();
        start_op(8'hAB, 8'hCD);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (if0.done !== 1'b0 || if0.p !== 16'h0000 || if0.busy !== 1'b0 || if0.ma !== 4'd0 || if0.mb !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: done=%0b p=%h busy=%0b ma=%h mb=%h, want all zero",
                     if0.done, if0.p, if0.busy, if0.ma, if0.mb);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cycle%0d: done=%0b busy=%0b, want 0 0", k, if0.done, if0.busy);
            end
        end
        start_op(8'h03, 8'h05);
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (if0.done !== 1'b1 || if0.p !== 16'h000F) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: done=%0b p=%h, want done=1 p=000f", if0.done, if0.p);
        end
        step();
    endtask

    // dut1 takes the shortcut, dut0 runs the full sequence on the same request.
    task automatic test_early_zero();
        logic nz_seen = 1'b0;
        start_op(8'h00, 8'h7E);
        n_checks++;
        if (if1.done !== 1'b1 || if1.p !== 16'h0000 || if1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL early_zero: done=%0b p=%h busy=%0b, want done=1 p=0000 busy=1",
                     if1.done, if1.p, if1.busy);
        end
        n_checks++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_zero_early: done=%0b busy=%0b, want done=0 busy=1", if0.done, if0.busy);
        end
        for (int k = 0; k < 4; k++) begin
            if (if1.ma !== 4'd0 || if1.mb !== 4'd0) nz_seen = 1'b1;
            step();
        end
        n_checks++;
        if (nz_seen !== 1'b0 || if1.done !== 1'b0 || if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_zero_after: nonzero_nibble=%0b done=%0b busy=%0b, want 0 0 0",
                     nz_seen, if1.done, if1.busy);
        end
        n_checks++;
        if (if0.done !== 1'b1 || if0.p !== 16'h0000) begin
            n_fail++;
            $display("FAIL full_zero: done=%0b p=%h, want done=1 p=0000", if0.done, if0.p);
        end
        step();
    endtask

    task automatic test_hold();
        start_op(8'h12, 8'h34);
        for (int k = 0; k < 5; k++) step();
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (if0.p !== 16'h03A8 || if0.done !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle%0d: p=%h done=%0b, want p=03a8 done=0", k, if0.p, if0.done);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        start_r = 1'b0;
        a_r = 8'd0;
        b_r = 8'd0;
        step();
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_mid_op();
        test_early_zero();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult8_sched.md
Name: mult8_sched

Overview:
- Sequencer that computes an unsigned 8x8 -> 16-bit product using one shared 4x4 array multiplier.
- The multiplier stays outside this block and stays combinational. This block drives its operand nibbles and reads back its 8-bit product.
- The multiplier is time-multiplexed over four partial-product cycles, and the results are accumulated with shifts.
- Sits between switch/register inputs and the existing 4x4 multiplier instance; its result feeds the hex display decoders.

Parameters:
EARLY_ZERO, 0, when 1 a Start with A==0 or B==0 skips the partial-product states and produces P=0 directly

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request new multiply; sampled only in IDLE
A  input  8  multiplicand, captured on accepted Start
B  input  8  multiplier, captured on accepted Start
MA  output  4  operand nibble to shared 4x4 multiplier (A side)
MB  output  4  operand nibble to shared 4x4 multiplier (B side)
MP  input  8  product returned by shared 4x4 multiplier (combinational, same cycle)
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse, result valid on P
P  output  16  last completed product, held until next completion

Behaviour:
- Reset (sampled high on a Clock edge):
  - State -> IDLE.
  - P=0, Done=0, Busy=0, MA=0, MB=0.
  - Internal A/B capture registers and accumulator cleared.
  - Reset overrides Start.
- Accepting a request:
  - Start is accepted only in IDLE. On that edge, capture Ar<=A, Br<=B, ACC<=0, and go to LL.
  - Start while Busy is ignored; no queueing.
- States and transitions:
  - IDLE -> LL on Start.
  - LL -> LH -> HL -> HH -> DONE -> IDLE, unconditional, one cycle each.
- Shared-multiplier drive and accumulation per state (MA, MB, accumulate):
  - LL: MA=Ar[3:0], MB=Br[3:0], ACC += MP.
  - LH: MA=Ar[3:0], MB=Br[7:4], ACC += MP<<4.
  - HL: MA=Ar[7:4], MB=Br[3:0], ACC += MP<<4.
  - HH: MA=Ar[7:4], MB=Br[7:4]. On this edge P <= ACC + (MP<<8), and Done is registered high.
  - MA=MB=0 in IDLE and DONE.
- Output timing:
  - Done is high exactly during the DONE state cycle.
  - P becomes valid in the same cycle Done rises.
- Arithmetic:
  - ACC is 16 bits and unsigned; all shifts are zero-filled.
  - Maximum result is 255*255=65025, so no overflow and no wrap handling is needed.
- Latency and throughput:
  - Start sampled at edge N -> Done high in cycle after edge N+4 (5 edges).
  - Busy is high from edge N through the DONE cycle.
  - Next Start is accepted at the earliest on the edge leaving DONE+1, i.e. in IDLE. Throughput is 1 op per 6 cycles.
- EARLY_ZERO=1 with A==0 or B==0 at accepted Start:
  - IDLE -> DONE directly; P <= 0 and Done pulses in the next cycle (latency 1 edge).
  - MA/MB stay 0.
  - With EARLY_ZERO=0, zero operands take the full path and also give P=0.
- Reset mid-operation:
  - Aborts the operation; no Done pulse.
  - P is cleared to 0 (reset value), not left at the old result.
- Operand stability: A/B may change after the accepted Start with no effect on the result in progress.
- Combinational path: MA/MB are decoded from state and capture registers only, never from A/B directly, so there is no combinational loop through MP.

Test Plan:
- Reset, then Start with A=0x12, B=0x34:
  - MA/MB sequence is (2,4),(2,3),(1,4),(1,3).
  - Done pulses 5 edges after Start with P=0x03A8 (936).
- A=0xFF, B=0xFF -> P=0xFE01 (65025), Done exactly one cycle, Busy high 5 cycles.
- Start held high continuously with A=0x0F, B=0x10:
  - Results are P=0x00F0, repeated every 6 cycles.
  - Start pulses during Busy are ignored, and A/B changes mid-op do not alter the result.
- Start A=0xAB, B=0xCD, assert Reset during HL:
  - No Done, P=0, Busy=0.
  - A fresh Start A=0x03, B=0x05 then gives P=0x000F.
- EARLY_ZERO=1, A=0x00, B=0x7E -> Done one edge after Start, P=0, MA/MB never nonzero.
- EARLY_ZERO=0 with the same operands -> Done after 5 edges, P=0.
- P hold: after P=0x03A8, idle 20 cycles -> P unchanged, Done stays 0.
